// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset controller.
// Holds the FSM state encoding, the opcode constants and the select
// encodings for the ALU operation, ALU B-source and PC source muxes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_R_WB     = 4'd7,
    ST_EXEC_I   = 4'd8,
    ST_I_WB     = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_IMM   = 2'd3;

  localparam logic [1:0] SRC_B_RT       = 2'd0;
  localparam logic [1:0] SRC_B_FOUR     = 2'd1;
  localparam logic [1:0] SRC_B_IMM      = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SHL2 = 2'd3;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

endpackage

// File: rtl/ctrl_opdecode.sv
// Combinational opcode classifier for the multicycle controller.
// Ports:
//   opcode       in  6  IR[31:26]
//   is_rtype     out    R-type ALU instruction
//   is_load      out    lw
//   is_store     out    sw
//   is_branch    out    beq or bne
//   is_bne       out    bne (branch taken on not-zero)
//   is_jump      out    j
//   is_imm_alu   out    addi / slti / andi / ori
//   imm_zero_ext out    immediate must be zero extended (andi / ori)
//   illegal      out    none of the above
module ctrl_opdecode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       is_rtype,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_bne,
  output logic       is_jump,
  output logic       is_imm_alu,
  output logic       imm_zero_ext,
  output logic       illegal
);

  assign is_rtype     = (opcode == OP_RTYPE);
  assign is_load      = (opcode == OP_LW);
  assign is_store     = (opcode == OP_SW);
  assign is_bne       = (opcode == OP_BNE);
  assign is_branch    = (opcode == OP_BEQ) || is_bne;
  assign is_jump      = (opcode == OP_J);
  assign imm_zero_ext = (opcode == OP_ANDI) || (opcode == OP_ORI);
  assign is_imm_alu   = (opcode == OP_ADDI) || (opcode == OP_SLTI) || imm_zero_ext;
  assign illegal      = !(is_rtype || is_load || is_store || is_branch ||
                          is_jump || is_imm_alu);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 32-bit MIPS-subset datapath.
// Sequences fetch/decode/execute/memory/write-back and drives every
// datapath select and enable. Stalls on mem_ready, traps on bad opcodes.
//
// state     | meaning
// ----------+-----------------------------------------------
// FETCH     | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE    | dispatch on opcode, precompute branch target
// MEM_ADDR  | ALUOut <= rs + sign_ext(imm)
// MEM_RD    | load data read, hold until mem_ready
// MEM_WB    | rt <= MDR
// MEM_WR    | store data write, hold until mem_ready
// EXEC_R    | ALU on rs, rt with funct-decoded operation
// R_WB      | rd <= ALUOut
// EXEC_I    | ALU on rs, extended immediate
// I_WB      | rt <= ALUOut
// BRANCH    | compare rs, rt; load PC from ALUOut when taken
// JUMP      | load PC with jump target
// TRAP      | unsupported opcode, halted until reset
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   opcode, funct         IR fields (funct goes straight to ALU control)
//   zero, mem_ready       ALU zero flag, memory access completion
//   pc_write .. pc_src    datapath enables, strobes and mux selects
//   halted, state_dbg     trap indication, current state encoding
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter logic RESET_PC_SEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       ext_sel,
  output logic [1:0] pc_src,
  output logic       halted,
  output logic [3:0] state_dbg
);

  state_t state, state_nxt;
  logic is_rtype, is_load, is_store, is_branch, is_bne, is_jump;
  logic is_imm_alu, imm_zero_ext, illegal;

  // funct is decoded by the ALU control block, not here.
  logic unused_funct;
  assign unused_funct = ^funct;

  ctrl_opdecode u_opdecode (
    .opcode       (opcode),
    .is_rtype     (is_rtype),
    .is_load      (is_load),
    .is_store     (is_store),
    .is_branch    (is_branch),
    .is_bne       (is_bne),
    .is_jump      (is_jump),
    .is_imm_alu   (is_imm_alu),
    .imm_zero_ext (imm_zero_ext),
    .illegal      (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:    if (mem_ready) state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (illegal)                   state_nxt = ST_TRAP;
        else if (is_rtype)             state_nxt = ST_EXEC_R;
        else if (is_load || is_store)  state_nxt = ST_MEM_ADDR;
        else if (is_branch)            state_nxt = ST_BRANCH;
        else if (is_jump)              state_nxt = ST_JUMP;
        else if (is_imm_alu)           state_nxt = ST_EXEC_I;
        else                           state_nxt = ST_TRAP;
      end
      ST_MEM_ADDR: state_nxt = is_store ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   if (mem_ready) state_nxt = ST_MEM_WB;
      ST_MEM_WB:   state_nxt = ST_FETCH;
      ST_MEM_WR:   if (mem_ready) state_nxt = ST_FETCH;
      ST_EXEC_R:   state_nxt = ST_R_WB;
      ST_R_WB:     state_nxt = ST_FETCH;
      ST_EXEC_I:   state_nxt = ST_I_WB;
      ST_I_WB:     state_nxt = ST_FETCH;
      ST_BRANCH:   state_nxt = ST_FETCH;
      ST_JUMP:     state_nxt = ST_FETCH;
      ST_TRAP:     state_nxt = ST_TRAP;
      default:     state_nxt = ST_TRAP;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_RT;
    alu_op     = ALU_ADD;
    ext_sel    = 1'b0;
    pc_src     = PC_SRC_ALU;
    halted     = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        // IR and PC load only on the cycle the fetch completes.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b = SRC_B_IMM_SHL2;
        ext_sel   = 1'b1;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        ext_sel   = 1'b1;
      end
      ST_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_IMM;
        ext_sel   = ~imm_zero_ext;
      end
      ST_I_WB: reg_write = 1'b1;
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_write  = is_bne ? ~zero : zero;
      end
      ST_JUMP: begin
        pc_src   = PC_SRC_JUMP;
        pc_write = 1'b1;
      end
      ST_TRAP: halted = 1'b1;
      default: ;
    endcase
    // Reset gates the decode directly so an in-flight strobe drops the
    // moment rst_n falls, without waiting for a clock edge.
    if (!rst_n) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRC_B_RT;
      alu_op     = ALU_ADD;
      ext_sel    = 1'b0;
      pc_src     = {1'b0, RESET_PC_SEL};
      halted     = 1'b0;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam logic TB_RESET_PC_SEL = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h20;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, ext_sel, halted;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state_dbg;
  logic [16:0] ctl_obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    state_t      st;
    logic [5:0]  opc;
    logic        mr;
    logic        z;
    logic [16:0] ctl;
  } row_t;

  row_t sb[$];

  multicycle_ctrl #(.RESET_PC_SEL(TB_RESET_PC_SEL)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .ext_sel(ext_sel), .pc_src(pc_src), .halted(halted), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign ctl_obs = {pc_write, ir_write, iord, mem_read, mem_write, reg_write,
                    reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                    ext_sel, pc_src, halted};

  // Expected control word, fields in the same order as ctl_obs.
  function automatic logic [16:0] c(input int pw, input int irw, input int io,
                                    input int mrd, input int mwr, input int rwe,
                                    input int rdst, input int m2r, input int asa,
                                    input int asb, input int aop, input int ext,
                                    input int ps, input int h);
    logic [1:0] asb2, aop2, ps2;
    asb2 = asb[1:0];
    aop2 = aop[1:0];
    ps2  = ps[1:0];
    return {pw[0], irw[0], io[0], mrd[0], mwr[0], rwe[0], rdst[0], m2r[0],
            asa[0], asb2, aop2, ext[0], ps2, h[0]};
  endfunction

  function automatic logic [16:0] reset_ctl();
    return c(0,0,0,0,0,0,0,0,0,0,0,0,{31'd0, TB_RESET_PC_SEL},0);
  endfunction

  task automatic push(input state_t st, input logic [5:0] opc, input logic mr,
                      input logic z, input logic [16:0] ctl);
    sb.push_back('{st:st, opc:opc, mr:mr, z:z, ctl:ctl});
  endtask

  // Non-memory states get mem_ready=0 to show it is ignored there.
  task automatic exp_fetch(input logic [5:0] opc, input int stalls);
    for (int i = 0; i < stalls; i++)
      push(ST_FETCH, opc, 1'b0, 1'b0, c(0,0,0,1,0,0,0,0,0,1,0,0,0,0));
    push(ST_FETCH, opc, 1'b1, 1'b0, c(1,1,0,1,0,0,0,0,0,1,0,0,0,0));
  endtask

  task automatic exp_decode(input logic [5:0] opc);
    push(ST_DECODE, opc, 1'b0, 1'b0, c(0,0,0,0,0,0,0,0,0,3,0,1,0,0));
  endtask

  task automatic exp_rtype();
    exp_fetch(OP_RTYPE, 0);
    exp_decode(OP_RTYPE);
    push(ST_EXEC_R, OP_RTYPE, 1'b0, 1'b0, c(0,0,0,0,0,0,0,0,1,0,2,0,0,0));
    push(ST_R_WB,   OP_RTYPE, 1'b0, 1'b0, c(0,0,0,0,0,1,1,0,0,0,0,0,0,0));
  endtask

  task automatic test_reset();
    row_t r;
    r = '{st:ST_FETCH, opc:OP_LW, mr:1'b1, z:1'b0, ctl:reset_ctl()};
    opcode = OP_LW; mem_ready = 1'b1;
    #3;
    checks++;
    if (state_dbg !== r.st || ctl_obs !== r.ctl) begin
      errors++;
      $display("FAIL reset_async: state %0d ctl %b, required state %0d ctl %b",
               state_dbg, ctl_obs, r.st, r.ctl);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (state_dbg !== r.st || ctl_obs !== r.ctl) begin
      errors++;
      $display("FAIL reset_held: state %0d ctl %b, required state %0d ctl %b",
               state_dbg, ctl_obs, r.st, r.ctl);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    row_t r;
    funct = 6'h20;
    exp_rtype();
    while (sb.size() != 0) begin
      r = sb.pop_front();
      opcode = r.opc; mem_ready = r.mr; zero = r.z;
      @(negedge clk);
      checks++;
      if (state_dbg !== r.st || ctl_obs !== r.ctl) begin
        errors++;
        $display("FAIL rtype: state %0d ctl %b, required state %0d ctl %b",
                 state_dbg, ctl_obs, r.st, r.ctl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_stall();
    row_t r;
    exp_fetch(OP_LW, 0);
    exp_decode(OP_LW);
    push(ST_MEM_ADDR, OP_LW, 1'b0, 1'b0, c(0,0,0,0,0,0,0,0,1,2,0,1,0,0));
    push(ST_MEM_RD,   OP_LW, 1'b0, 1'b0, c(0,0,1,1,0,0,0,0,0,0,0,0,0,0));
    push(ST_MEM_RD,   OP_LW, 1'b0, 1'b0, c(0,0,1,1,0,0,0,0,0,0,0,0,0,0));
    push(ST_MEM_RD,   OP_LW, 1'b1, 1'b0, c(0,0,1,1,0,0,0,0,0,0,0,0,0,0));
    push(ST_MEM_WB,   OP_LW, 1'b0, 1'b0, c(0,0,0,0,0,1,0,1,0,0,0,0,0,0));
    while (sb.size() != 0) begin
      r = sb.pop_front();
      opcode = r.opc; mem_ready = r.mr; zero = r.z;
      @(negedge clk);
      checks++;
      if (state_dbg !== r.st || ctl_obs !== r.ctl) begin
        errors++;
        $display("FAIL lw_stall: state %0d ctl %b, required state %0d ctl %b",
                 state_dbg, ctl_obs, r.st, r.ctl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    row_t r;
    logic [5:0] ops [4] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
    logic       zs  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int         pws [4] = '{1, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      exp_fetch(ops[i], 0);
      exp_decode(ops[i]);
      push(ST_BRANCH, ops[i], 1'b0, zs[i], c(pws[i],0,0,0,0,0,0,0,1,0,1,0,1,0));
    end
    exp_fetch(OP_J, 1);
    exp_decode(OP_J);
    push(ST_JUMP, OP_J, 1'b0, 1'b0, c(1,0,0,0,0,0,0,0,0,0,0,0,2,0));
    while (sb.size() != 0) begin
      r = sb.pop_front();
      opcode = r.opc; mem_ready = r.mr; zero = r.z;
      @(negedge clk);
      checks++;
      if (state_dbg !== r.st || ctl_obs !== r.ctl) begin
        errors++;
        $display("FAIL branch_jump: op %h state %0d ctl %b, required state %0d ctl %b",
                 r.opc, state_dbg, ctl_obs, r.st, r.ctl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_imm();
    row_t r;
    logic [5:0] ops  [4] = '{OP_ANDI, OP_ADDI, OP_ORI, OP_SLTI};
    int         exts [4] = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      exp_fetch(ops[i], 0);
      exp_decode(ops[i]);
      push(ST_EXEC_I, ops[i], 1'b0, 1'b0, c(0,0,0,0,0,0,0,0,1,2,3,exts[i],0,0));
      push(ST_I_WB,   ops[i], 1'b0, 1'b0, c(0,0,0,0,0,1,0,0,0,0,0,0,0,0));
    end
    while (sb.size() != 0) begin
      r = sb.pop_front();
      opcode = r.opc; mem_ready = r.mr; zero = r.z;
      @(negedge clk);
      checks++;
      if (state_dbg !== r.st || ctl_obs !== r.ctl) begin
        errors++;
        $display("FAIL imm_alu: op %h state %0d ctl %b, required state %0d ctl %b",
                 r.opc, state_dbg, ctl_obs, r.st, r.ctl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_trap();
    row_t r;
    exp_fetch(6'h3F, 0);
    exp_decode(6'h3F);
    for (int i = 0; i < 20; i++)
      push(ST_TRAP, 6'h3F, i[0], i[1], c(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
    while (sb.size() != 0) begin
      r = sb.pop_front();
      opcode = r.opc; mem_ready = r.mr; zero = r.z;
      @(negedge clk);
      checks++;
      if (state_dbg !== r.st || ctl_obs !== r.ctl) begin
        errors++;
        $display("FAIL trap: state %0d ctl %b, required state %0d ctl %b",
                 state_dbg, ctl_obs, r.st, r.ctl);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (state_dbg !== ST_FETCH || ctl_obs !== reset_ctl()) begin
      errors++;
      $display("FAIL trap_reset_exit: state %0d ctl %b, required state %0d ctl %b",
               state_dbg, ctl_obs, ST_FETCH, reset_ctl());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sw_reset();
    row_t r;
    exp_fetch(OP_SW, 1);
    exp_decode(OP_SW);
    push(ST_MEM_ADDR, OP_SW, 1'b0, 1'b0, c(0,0,0,0,0,0,0,0,1,2,0,1,0,0));
    push(ST_MEM_WR,   OP_SW, 1'b0, 1'b0, c(0,0,1,0,1,0,0,0,0,0,0,0,0,0));
    push(ST_MEM_WR,   OP_SW, 1'b0, 1'b0, c(0,0,1,0,1,0,0,0,0,0,0,0,0,0));
    while (sb.size() != 0) begin
      r = sb.pop_front();
      opcode = r.opc; mem_ready = r.mr; zero = r.z;
      @(negedge clk);
      checks++;
      if (state_dbg !== r.st || ctl_obs !== r.ctl) begin
        errors++;
        $display("FAIL sw_stall: state %0d ctl %b, required state %0d ctl %b",
                 state_dbg, ctl_obs, r.st, r.ctl);
      end
      @(posedge clk); #1;
    end
    // Still stalled in MEM_WR; pull reset between clock edges.
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b1 || state_dbg !== ST_MEM_WR) begin
      errors++;
      $display("FAIL sw_pre_reset: mem_write %b state %0d, required mem_write 1 state %0d",
               mem_write, state_dbg, ST_MEM_WR);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0 || state_dbg !== ST_FETCH || ctl_obs !== reset_ctl()) begin
      errors++;
      $display("FAIL sw_reset_drop: mem_write %b state %0d ctl %b, required mem_write 0 state %0d ctl %b",
               mem_write, state_dbg, ctl_obs, ST_FETCH, reset_ctl());
    end
    #1;
    rst_n = 1'b1;
    exp_rtype();
    exp_fetch(OP_RTYPE, 0);
    while (sb.size() != 0) begin
      r = sb.pop_front();
      opcode = r.opc; mem_ready = r.mr; zero = r.z;
      @(negedge clk);
      checks++;
      if (state_dbg !== r.st || ctl_obs !== r.ctl) begin
        errors++;
        $display("FAIL sw_restart: state %0d ctl %b, required state %0d ctl %b",
                 state_dbg, ctl_obs, r.st, r.ctl);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_branch();
    test_imm();
    test_trap();
    test_sw_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
